booth_wallace_mul_pipe: RTL and testbench

- Parametrised, pipelined radix-4 Booth / Wallace-tree multiplier. Successor to the combinational 16x16 approximate multiplier.
- Adds generic operand width, signed/unsigned mode and a 3-stage registered pipeline with a valid/ready handshake.
- Keeps operand/result sizing masks and a per-operation approximation level.
- Sits in the core execute stage behind the M-extension decoder, feeding the writeback mux.

---
 rtl/booth_wallace_mul_pipe.sv | 166 ++++++++++++++++
 tb/tb_booth_wallace_mul_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_wallace_mul_pipe.sv
// Purpose: pipelined radix-4 Booth / carry-save-tree multiplier with operand and result masks and low-column truncation.
// Latency: 3 cycles from accept to out_valid (PP register, tree register, final-add register); 1 beat per cycle.
// Backpressure: one global stall, in_ready = !out_valid || out_ready; when stalled every stage holds its contents.
module booth_wallace_mul_pipe #(
    parameter int WIDTH       = 16,
    parameter int APPROX_STEP = 4,
    parameter int MAX_APPROX  = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               is_signed,
    input  logic [2:0]         approx_level,
    input  logic [WIDTH-1:0]   size_x,
    input  logic [WIDTH-1:0]   size_y,
    input  logic [2*WIDTH-1:0] size_add,
    input  logic [WIDTH-1:0]   X,
    input  logic [WIDTH-1:0]   Y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result
);
    localparam int RW  = 2 * WIDTH;
    localparam int NPP = WIDTH / 2 + 1;
    localparam int EW  = WIDTH + 2;

    // Row count entering a given 3:2 level of the reduction tree.
    function automatic int rows_at(input int lvl);
        int n;
        n = NPP;
        for (int i = 0; i < lvl; i++) begin
            if (n > 3) n = n - n / 3;
        end
        return n;
    endfunction

    // Number of 3:2 levels needed to bring NPP rows down to three.
    function automatic int num_levels(input int rows);
        int n;
        int l;
        n = rows;
        l = 0;
        while (n > 3) begin
            n = n - n / 3;
            l++;
        end
        return l;
    endfunction

    localparam int NLV = num_levels(NPP);

    logic          advance;
    logic          v1_q, v2_q, out_valid_q;
    logic [RW-1:0] pp_d [NPP];
    logic [RW-1:0] pp_q [NPP];
    logic [2:0]    apx1_q, apx2_q;
    logic [RW-1:0] sa1_q, sa2_q;
    logic [RW-1:0] sum_d, carry_d, sum_q, carry_q;
    logic [RW-1:0] res_d, result_q;

    logic [WIDTH-1:0] xm_c, ym_c;
    logic [RW-1:0]    xs_c, mag_c;
    logic [EW:0]      yp_c;
    logic             b2_c, b1_c, b0_c;

    assign advance   = !out_valid_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign result    = result_q;

    // Stage 1: mask, extend, and form one Booth partial product per radix-4 digit of Y.
    always_comb begin
        xm_c  = X & size_x;
        ym_c  = Y & size_y;
        xs_c  = is_signed ? {{WIDTH{xm_c[WIDTH-1]}}, xm_c} : {{WIDTH{1'b0}}, xm_c};
        // Two extra high bits make the top digit the unsigned correction digit.
        yp_c  = {(is_signed ? {2{ym_c[WIDTH-1]}} : 2'b00), ym_c, 1'b0};
        mag_c = '0;
        b2_c  = 1'b0;
        b1_c  = 1'b0;
        b0_c  = 1'b0;
        for (int i = 0; i < NPP; i++) begin
            b2_c  = yp_c[2*i+2];
            b1_c  = yp_c[2*i+1];
            b0_c  = yp_c[2*i];
            mag_c = '0;
            if (b1_c ^ b0_c)      mag_c = xs_c;
            else if (b2_c != b1_c) mag_c = xs_c << 1;
            // Negative digits: two's-complement negate in the full product width.
            if (b2_c)             mag_c = ~mag_c + RW'(1);
            pp_d[i] = mag_c << (2 * i);
        end
    end

    // Stage 2: 3:2 carry-save levels reduce NPP rows to three, then a final 3:2 gives sum/carry.
    logic [RW-1:0] lv [NLV+1][NPP];

    for (genvar k = 0; k < NPP; k++) begin : g_lv0
        assign lv[0][k] = pp_q[k];
    end

    for (genvar l = 0; l < NLV; l++) begin : g_lvl
        localparam int NI = rows_at(l);
        localparam int G  = NI / 3;
        for (genvar k = 0; k < NPP; k++) begin : g_row
            if (k < 2 * G) begin : g_csa
                localparam int B = 3 * (k / 2);
                if (k % 2 == 0) begin : g_s
                    assign lv[l+1][k] = lv[l][B] ^ lv[l][B+1] ^ lv[l][B+2];
                end else begin : g_c
                    assign lv[l+1][k] = ((lv[l][B] & lv[l][B+1]) | (lv[l][B] & lv[l][B+2]) |
                                         (lv[l][B+1] & lv[l][B+2])) << 1;
                end
            end else if (k < NI - G) begin : g_pass
                assign lv[l+1][k] = lv[l][k+G];
            end else begin : g_zero
                assign lv[l+1][k] = '0;
            end
        end
    end

    // Carry is kept unshifted; the final adder applies the <<1.
    assign sum_d   = lv[NLV][0] ^ lv[NLV][1] ^ lv[NLV][2];
    assign carry_d = (lv[NLV][0] & lv[NLV][1]) | (lv[NLV][0] & lv[NLV][2]) | (lv[NLV][1] & lv[NLV][2]);

    // Stage 3: carry-propagate add, clear the L lowest columns, apply the result mask.
    logic [RW-1:0] p_c, keep_c;
    int            lvl_c, l_c;
    always_comb begin
        p_c   = sum_q + (carry_q << 1);
        lvl_c = (int'(apx2_q) > MAX_APPROX) ? MAX_APPROX : int'(apx2_q);
        l_c   = lvl_c * APPROX_STEP;
        keep_c = (l_c >= RW) ? '0 : ({RW{1'b1}} << l_c);
        res_d = p_c & keep_c & sa2_q;
    end

    // Pipeline registers: all stages advance together, valid bits travel with their data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NPP; i++) pp_q[i] <= '0;
            apx1_q      <= '0;
            apx2_q      <= '0;
            sa1_q       <= '0;
            sa2_q       <= '0;
            sum_q       <= '0;
            carry_q     <= '0;
            result_q    <= '0;
        end else if (advance) begin
            v1_q        <= in_valid;
            for (int i = 0; i < NPP; i++) pp_q[i] <= pp_d[i];
            apx1_q      <= approx_level;
            sa1_q       <= size_add;
            v2_q        <= v1_q;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            apx2_q      <= apx1_q;
            sa2_q       <= sa1_q;
            out_valid_q <= v2_q;
            result_q    <= res_d;
        end
    end
endmodule

// File: tb/tb_booth_wallace_mul_pipe.sv
// Purpose: scoreboard bench for booth_wallace_mul_pipe at WIDTH=16 against an arithmetic reference product.
// Latency: directed beats check the 3-cycle accept-to-out_valid latency.
// Backpressure: exercises held outputs under out_ready low, random stalls, bubbles and a mid-flight reset.
module tb_booth_wallace_mul_pipe;
    localparam int W  = 16;
    localparam int RW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          is_signed = 1'b0;
    logic [2:0]    approx_level = '0;
    logic [W-1:0]  size_x = '1;
    logic [W-1:0]  size_y = '1;
    logic [RW-1:0] size_add = '1;
    logic [W-1:0]  X = '0;
    logic [W-1:0]  Y = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [RW-1:0] result;

    booth_wallace_mul_pipe #(.WIDTH(W), .APPROX_STEP(4), .MAX_APPROX(7)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .is_signed(is_signed), .approx_level(approx_level), .size_x(size_x), .size_y(size_y),
        .size_add(size_add), .X(X), .Y(Y), .out_valid(out_valid), .out_ready(out_ready),
        .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] exp;
        int            acc;
        bit            lat;
    } ent_t;

    ent_t          sbq[$];
    logic [RW-1:0] pend_exp = '0;
    bit            pend_lat = 1'b0;
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;
    bit            held = 1'b0;
    logic [RW-1:0] held_val = '0;
    bit            front_seen = 1'b0;
    bit            rnd_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer product of the masked operands, low L columns cleared, result mask applied.
    function automatic logic [RW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                            input logic [2:0] apx, input logic [W-1:0] sx,
                                            input logic [W-1:0] sy, input logic [RW-1:0] sa);
        logic [W-1:0]  xm, ym;
        longint        xv, yv;
        logic [RW-1:0] p;
        int            l;
        xm = x & sx;
        ym = y & sy;
        xv = s ? longint'($signed(xm)) : longint'(xm);
        yv = s ? longint'($signed(ym)) : longint'(ym);
        p  = RW'(xv * yv);
        l  = int'(apx) * 4;
        if (l >= RW) return '0;
        return ((p >> l) << l) & sa;
    endfunction

    // Accept monitor: a beat seen with valid && ready here is captured at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            ent_t e;
            e.exp = pend_exp;
            e.acc = cyc;
            e.lat = pend_lat;
            sbq.push_back(e);
        end
    end

    // Output monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk(!out_valid, "reset_out_valid", 64'(out_valid), 64'd0);
            chk(result == '0, "reset_result", 64'(result), 64'd0);
            chk(in_ready, "reset_in_ready", 64'(in_ready), 64'd1);
            held = 1'b0;
            front_seen = 1'b0;
        end else begin
            chk(in_ready == (!out_valid || out_ready), "in_ready_rule", 64'(in_ready),
                64'(!out_valid || out_ready));
            if (held) begin
                chk(out_valid, "hold_valid", 64'(out_valid), 64'd1);
                chk(result == held_val, "hold_result", 64'(result), 64'(held_val));
            end
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    chk(1'b0, "spurious_output", 64'(result), 64'd0);
                end else begin
                    chk(result == sbq[0].exp, "result", 64'(result), 64'(sbq[0].exp));
                    if (sbq[0].lat && !front_seen)
                        chk(cyc - sbq[0].acc == 3, "latency", 64'(cyc - sbq[0].acc), 64'd3);
                    front_seen = 1'b1;
                    if (out_ready) begin
                        void'(sbq.pop_front());
                        front_seen = 1'b0;
                    end
                end
            end
            held = out_valid && !out_ready;
            held_val = result;
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input logic [2:0] apx,
                        input logic [W-1:0] sx, input logic [W-1:0] sy, input logic [RW-1:0] sa,
                        input logic [RW-1:0] exp, input bit lat);
        int g;
        X = x; Y = y; is_signed = s; approx_level = apx;
        size_x = sx; size_y = sy; size_add = sa;
        pend_exp = exp; pend_lat = lat;
        in_valid = 1'b1;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!in_ready && g < 200);
        if (!in_ready) chk(1'b0, "accept_timeout", 64'(g), 64'd200);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input bit lat);
        logic [W-1:0]  x, y, sx, sy;
        logic [RW-1:0] sa;
        logic          s;
        logic [2:0]    a;
        x  = W'($urandom);
        y  = W'($urandom);
        if ($urandom_range(0, 7) == 0) x = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
        if ($urandom_range(0, 7) == 0) y = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'hFFFF;
        s  = 1'($urandom_range(0, 1));
        a  = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'($urandom_range(0, 7));
        sx = ($urandom_range(0, 3) == 0) ? W'($urandom) : '1;
        sy = ($urandom_range(0, 3) == 0) ? W'($urandom) : '1;
        sa = ($urandom_range(0, 3) == 0) ? RW'($urandom) : '1;
        send(x, y, s, a, sx, sy, sa, model(x, y, s, a, sx, sy, sa), lat);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sbq.size() != 0 && g < 500) begin
            @(posedge clk);
            g++;
        end
        chk(sbq.size() == 0, "drain", 64'(sbq.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors with hand-derived products.
        send(16'hFFFF, 16'hFFFF, 1'b0, 3'd0, '1, '1, '1, 32'hFFFE0001, 1'b1);
        send(16'hFFFD, 16'h0005, 1'b1, 3'd0, '1, '1, '1, 32'hFFFFFFF1, 1'b1);
        send(16'h8000, 16'h8000, 1'b1, 3'd0, '1, '1, '1, 32'h40000000, 1'b1);
        send(16'h1234, 16'h5678, 1'b0, 3'd0, '1, '1, '1, 32'h06260060, 1'b1);
        send(16'h1234, 16'h5678, 1'b0, 3'd2, '1, '1, '1, 32'h06260000, 1'b1);
        send(16'h1234, 16'h5678, 1'b0, 3'd3, '1, '1, '1, 32'h06260000, 1'b1);
        send(16'h1234, 16'h5678, 1'b0, 3'd0, 16'h00FF, '1, '1, 32'h00119060, 1'b1);
        send(16'hFFFF, 16'hFFFF, 1'b0, 3'd7, '1, '1, '1, 32'hF0000000, 1'b1);
        send(16'hFFFF, 16'hFFFF, 1'b0, 3'd0, '1, '1, 32'h0000FFFF, 32'h00000001, 1'b1);
        send(16'h8000, 16'h7FFF, 1'b1, 3'd0, '1, '1, '1, 32'hC0008000, 1'b1);
        drain();

        // Stream of 8 random beats with a 5-cycle output stall.
        fork
            begin
                for (int i = 0; i < 8; i++) send_rand(1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset pulse with two beats in flight; nothing may emerge afterwards.
        send(16'h0003, 16'h0004, 1'b0, 3'd0, '1, '1, '1, 32'h0000000C, 1'b0);
        send(16'h0005, 16'h0006, 1'b0, 3'd0, '1, '1, '1, 32'h0000001E, 1'b0);
        rst_n = 1'b0;
        sbq.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(16'h0007, 16'h0009, 1'b0, 3'd0, '1, '1, '1, 32'h0000003F, 1'b1);
        drain();

        // Random sweep with bubbles and random output backpressure.
        fork
            begin
                for (int i = 0; i < 3000; i++) begin
                    repeat ($urandom_range(0, 1)) begin
                        @(posedge clk);
                        #1;
                    end
                    send_rand(1'b0);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
